// File: rtl/xor_sweep_checker.sv
// Exhaustive self-checking driver for a 4-input XOR gate. Sweeps all 16 input
// vectors, holds each for SETTLE_CYCLES+1 cycles, samples the gate output on the
// last edge of that window and compares it against the expected parity.
module xor_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_q,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_fail,
  output logic             first_fail_valid
);

  // Settle counter must hold values 0..SETTLE_CYCLES; keep at least one bit.
  localparam int unsigned CntW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] SettleMax = CntW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [3:0]       first_fail_q, first_fail_d;
  logic             first_fail_valid_q, first_fail_valid_d;
  logic             fail_seen_q, fail_seen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             sample_edge;
  logic             mismatch;

  // The sample edge is also the edge that advances idx, so compare against the
  // pre-advance vector.
  assign sample_edge = (state_q == StRun) && (cnt_q == SettleMax);
  assign mismatch    = dut_q ^ (^idx_q);

  // Next-state and sweep bookkeeping.
  always_comb begin
    state_d            = state_q;
    idx_d              = idx_q;
    cnt_d              = cnt_q;
    err_count_d        = err_count_q;
    first_fail_d       = first_fail_q;
    first_fail_valid_d = first_fail_valid_q;
    fail_seen_d        = fail_seen_q;
    busy_d             = busy_q;
    done_d             = done_q;
    pass_d             = pass_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d            = StRun;
          idx_d              = 4'd0;
          cnt_d              = '0;
          err_count_d        = '0;
          first_fail_d       = 4'd0;
          first_fail_valid_d = 1'b0;
          fail_seen_d        = 1'b0;
          busy_d             = 1'b1;
          done_d             = 1'b0;
          pass_d             = 1'b0;
        end
      end

      StRun: begin
        if (!sample_edge) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (mismatch) begin
            fail_seen_d = 1'b1;
            if (err_count_q != {ERR_W{1'b1}}) begin
              err_count_d = err_count_q + 1'b1;
            end
            if (!first_fail_valid_q) begin
              first_fail_d       = idx_q;
              first_fail_valid_d = 1'b1;
            end
          end
          if (idx_q != 4'd15) begin
            idx_d = idx_q + 4'd1;
          end else begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Sticky flag rather than err_count so saturation cannot hide a failure.
            pass_d  = !(fail_seen_q || mismatch);
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= StIdle;
      idx_q              <= 4'd0;
      cnt_q              <= '0;
      err_count_q        <= '0;
      first_fail_q       <= 4'd0;
      first_fail_valid_q <= 1'b0;
      fail_seen_q        <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      idx_q              <= idx_d;
      cnt_q              <= cnt_d;
      err_count_q        <= err_count_d;
      first_fail_q       <= first_fail_d;
      first_fail_valid_q <= first_fail_valid_d;
      fail_seen_q        <= fail_seen_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      pass_q             <= pass_d;
    end
  end

  // Gate inputs are decoded from registered state only; idle vector is all-zero.
  always_comb begin
    {a, b, c, d} = 4'd0;
    if (state_q == StRun) begin
      {a, b, c, d} = idx_q;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_count_q;
  assign first_fail       = first_fail_q;
  assign first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_xor_sweep_checker.sv
// Directed bench for xor_sweep_checker: ideal, stuck-at-0 and inverted gate
// models, mid-sweep reset, back-to-back sweeps and zero settle time.
module tb_xor_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  // Main instance: SETTLE_CYCLES=2, ERR_W=5; mode 0 ideal gate, 1 stuck at 0.
  int         main_mode = 0;
  logic       m_start = 1'b0;
  logic       m_q;
  logic       m_a, m_b, m_c, m_d, m_busy, m_done, m_pass, m_ffv;
  logic [4:0] m_err;
  logic [3:0] m_ff;

  assign m_q = (main_mode == 1) ? 1'b0 : (m_a ^ m_b ^ m_c ^ m_d);

  xor_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(5)) u_main (
    .clk(clk), .rst_n(rst_n), .start(m_start), .dut_q(m_q),
    .a(m_a), .b(m_b), .c(m_c), .d(m_d),
    .busy(m_busy), .done(m_done), .pass(m_pass),
    .err_count(m_err), .first_fail(m_ff), .first_fail_valid(m_ffv)
  );

  // Inverted gate with a 4-bit counter to exercise saturation.
  logic       v_start = 1'b0;
  logic       v_q;
  logic       v_a, v_b, v_c, v_d, v_busy, v_done, v_pass, v_ffv;
  logic [3:0] v_err;
  logic [3:0] v_ff;

  assign v_q = ~(v_a ^ v_b ^ v_c ^ v_d);

  xor_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) u_inv (
    .clk(clk), .rst_n(rst_n), .start(v_start), .dut_q(v_q),
    .a(v_a), .b(v_b), .c(v_c), .d(v_d),
    .busy(v_busy), .done(v_done), .pass(v_pass),
    .err_count(v_err), .first_fail(v_ff), .first_fail_valid(v_ffv)
  );

  // Ideal gate with zero settle time.
  logic       z_start = 1'b0;
  logic       z_q;
  logic       z_a, z_b, z_c, z_d, z_busy, z_done, z_pass, z_ffv;
  logic [4:0] z_err;
  logic [3:0] z_ff;

  assign z_q = z_a ^ z_b ^ z_c ^ z_d;

  xor_sweep_checker #(.SETTLE_CYCLES(0), .ERR_W(5)) u_zero (
    .clk(clk), .rst_n(rst_n), .start(z_start), .dut_q(z_q),
    .a(z_a), .b(z_b), .c(z_c), .d(z_d),
    .busy(z_busy), .done(z_done), .pass(z_pass),
    .err_count(z_err), .first_fail(z_ff), .first_fail_valid(z_ffv)
  );

  always @(negedge clk) begin
    if ((m_busy && m_done) || (v_busy && v_done) || (z_busy && z_done)) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; n = edges after the start edge until done is seen.
  task automatic sweep_main(output int n, output bit vec_ok);
    @(negedge clk); m_start = 1'b1;
    @(negedge clk); m_start = 1'b0;
    n = 0;
    vec_ok = 1'b1;
    while (!m_done && n < 200) begin
      if ({m_a, m_b, m_c, m_d} !== 4'(n / 3)) vec_ok = 1'b0;
      @(negedge clk); n++;
    end
  endtask

  task automatic sweep_inv(output int n);
    @(negedge clk); v_start = 1'b1;
    @(negedge clk); v_start = 1'b0;
    n = 0;
    while (!v_done && n < 200) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic sweep_zero(output int n, output bit vec_ok);
    @(negedge clk); z_start = 1'b1;
    @(negedge clk); z_start = 1'b0;
    n = 0;
    vec_ok = 1'b1;
    while (!z_done && n < 200) begin
      if ({z_a, z_b, z_c, z_d} !== 4'(n)) vec_ok = 1'b0;
      @(negedge clk); n++;
    end
  endtask

  initial begin
    int  n;
    bit  vok;
    int  done_cycles;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_pass", 32'(m_pass), 32'd0);
    check("rst_err", 32'(m_err), 32'd0);
    check("rst_vec", 32'({m_a, m_b, m_c, m_d}), 32'd0);
    check("rst_ffv", 32'(m_ffv), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Ideal gate, default settle.
    main_mode = 0;
    sweep_main(n, vok);
    check("ideal_latency", 32'(n), 32'd48);
    check("ideal_vectors", 32'(vok), 32'd1);
    check("ideal_pass", 32'(m_pass), 32'd1);
    check("ideal_err", 32'(m_err), 32'd0);
    check("ideal_ffv", 32'(m_ffv), 32'd0);
    check("ideal_busy", 32'(m_busy), 32'd0);
    check("done_vec_zero", 32'({m_a, m_b, m_c, m_d}), 32'd0);

    // Stuck-at-0 gate: odd-parity vectors fail, first is 0001.
    main_mode = 1;
    sweep_main(n, vok);
    check("stuck_latency", 32'(n), 32'd48);
    check("stuck_err", 32'(m_err), 32'd8);
    check("stuck_ff", 32'(m_ff), 32'd1);
    check("stuck_ffv", 32'(m_ffv), 32'd1);
    check("stuck_pass", 32'(m_pass), 32'd0);

    // Inverted gate: 16 mismatches saturate a 4-bit counter at 15.
    sweep_inv(n);
    check("inv_latency", 32'(n), 32'd48);
    check("inv_err", 32'(v_err), 32'd15);
    check("inv_ff", 32'(v_ff), 32'd0);
    check("inv_ffv", 32'(v_ffv), 32'd1);
    check("inv_pass", 32'(v_pass), 32'd0);

    // Reset mid-sweep while idx=7; vectors 1,2,4 have already failed.
    main_mode = 1;
    @(negedge clk); m_start = 1'b1;
    @(negedge clk); m_start = 1'b0;
    repeat (22) @(negedge clk);
    check("mid_vec", 32'({m_a, m_b, m_c, m_d}), 32'd7);
    check("mid_err", 32'(m_err), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(m_busy), 32'd0);
    check("mid_rst_done", 32'(m_done), 32'd0);
    check("mid_rst_vec", 32'({m_a, m_b, m_c, m_d}), 32'd0);
    check("mid_rst_err", 32'(m_err), 32'd0);
    check("mid_rst_ffv", 32'(m_ffv), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    main_mode = 0;
    sweep_main(n, vok);
    check("post_rst_latency", 32'(n), 32'd48);
    check("post_rst_pass", 32'(m_pass), 32'd1);

    // Start held high: back-to-back sweeps, done high one cycle between them.
    main_mode = 1;
    @(negedge clk); m_start = 1'b1;
    @(negedge clk);
    n = 0;
    done_cycles = 0;
    while (n < 110) begin
      if (m_done) done_cycles++;
      if (n == 47) check("b2b_not_done_47", 32'(m_done), 32'd0);
      if (n == 48) check("b2b_err_first", 32'(m_err), 32'd8);
      if (n == 48) check("b2b_done_48", 32'(m_done), 32'd1);
      if (n == 49) check("b2b_restart_busy", 32'(m_busy), 32'd1);
      if (n == 49) check("b2b_restart_done", 32'(m_done), 32'd0);
      if (n == 49) check("b2b_err_cleared", 32'(m_err), 32'd0);
      if (n == 97) check("b2b_err_second", 32'(m_err), 32'd8);
      @(negedge clk); n++;
    end
    check("b2b_done_cycles", 32'(done_cycles), 32'd2);
    m_start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Zero settle: new vector every edge, done after 16 edges.
    sweep_zero(n, vok);
    check("zero_latency", 32'(n), 32'd16);
    check("zero_vectors", 32'(vok), 32'd1);
    check("zero_pass", 32'(z_pass), 32'd1);
    check("zero_err", 32'(z_err), 32'd0);

    check("busy_done_overlap", 32'(overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
